// File: rtl/led_anim_pkg.sv
// Shared pattern-select encodings and reset pattern for the LED animator.
package led_anim_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROT_L  = 2'd1,
        MODE_ROT_R  = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    // Zero-extended to the bar width: only bit0 lit.
    localparam logic [0:0] LED_RESET_PAT = 1'b1;

endpackage

// File: rtl/led_animator_tick_gen.sv
// Step-rate prescaler: one tick every div+1 enabled cycles.
module tick_gen #(
    parameter int unsigned DIV_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    // >= so that lowering div below the running count ticks immediately
    assign wrap = (cnt >= div);
    assign tick = en && !clr && wrap;

    // Prescale counter; clr (pattern reload) restarts the period
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_animator.sv
// LED bar animator: bounce, rotate-left, rotate-right and fill/drain patterns.
module led_animator
    import led_anim_pkg::*;
#(
    parameter int unsigned N_LEDS = 18,
    parameter int unsigned DIV_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [DIV_W-1:0]  div,
    output logic [N_LEDS-1:0] leds,
    output logic              dir,
    output logic              step
);

    localparam logic [N_LEDS-1:0] LEDS_RST = N_LEDS'(LED_RESET_PAT);

    generate
        if (N_LEDS < 2) begin : g_n_leds_check
            $error("led_animator: N_LEDS must be >= 2");
        end
    endgenerate

    logic [MODE_W-1:0] mode_q;
    logic              mode_chg;
    logic              tick;
    logic [N_LEDS-1:0] leds_d;
    logic              dir_d;
    logic              step_d;

    assign mode_chg = (mode != mode_q);

    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (mode_chg),
        .div  (div),
        .tick (tick)
    );

    // Next pattern: mode change reloads, otherwise a tick advances the active pattern
    always_comb begin
        leds_d = leds;
        dir_d  = dir;
        step_d = 1'b0;
        if (mode_chg) begin
            leds_d = LEDS_RST;
            dir_d  = 1'b0;
        end else if (tick) begin
            step_d = 1'b1;
            if (mode_q == MODE_FILL) begin
                if (!dir) begin
                    if (&leds) begin
                        dir_d  = 1'b1;
                        leds_d = leds << 1;
                    end else begin
                        leds_d = {leds[N_LEDS-2:0], 1'b1};
                    end
                end else begin
                    if (leds == '0) begin
                        dir_d  = 1'b0;
                        leds_d = LEDS_RST;
                    end else begin
                        leds_d = leds << 1;
                    end
                end
            end else if (!$onehot(leds)) begin
                // single-dot patterns recover from a corrupted bar
                leds_d = LEDS_RST;
                dir_d  = 1'b0;
            end else begin
                case (mode_q)
                    MODE_ROT_L: begin
                        leds_d = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
                        dir_d  = 1'b0;
                    end
                    MODE_ROT_R: begin
                        leds_d = {leds[0], leds[N_LEDS-1:1]};
                        dir_d  = 1'b1;
                    end
                    default: begin
                        if (!dir && leds[N_LEDS-1]) begin
                            dir_d  = 1'b1;
                            leds_d = leds >> 1;
                        end else if (dir && leds[0]) begin
                            dir_d  = 1'b0;
                            leds_d = leds << 1;
                        end else if (dir) begin
                            leds_d = leds >> 1;
                        end else begin
                            leds_d = leds << 1;
                        end
                    end
                endcase
            end
        end
    end

    // Pattern, direction, step pulse and mode history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            leds   <= LEDS_RST;
            dir    <= 1'b0;
            step   <= 1'b0;
            mode_q <= mode;
        end else begin
            leds   <= leds_d;
            dir    <= dir_d;
            step   <= step_d;
            mode_q <= mode;
        end
    end

endmodule

// File: tb/tb_led_animator.sv
// Self-checking bench for led_animator (N_LEDS = 4, DIV_W = 4).
module tb_led_animator;

    localparam int N = 4;
    localparam int FULL = (1 << N) - 1;
    localparam logic [N-1:0] DEP_PAT = 4'b0110;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [3:0]   div;
    logic [N-1:0] leds;
    logic         dir;
    logic         step;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: steps since last reload, prescale count, sampled mode
    int       t_m;
    int       cnt_m;
    logic [1:0] mq_m;
    bit       ill_m   = 1'b0;
    bit       step_m;
    bit       valid_m = 1'b0;
    bit       chg_m;
    bit       tk_m;

    led_animator #(
        .N_LEDS (N),
        .DIV_W  (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .div  (div),
        .leds (leds),
        .dir  (dir),
        .step (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pattern as a function of steps taken since the last reload
    function automatic logic [N-1:0] exp_leds(input logic [1:0] m, input int t, input bit ill);
        int k;
        int pos;
        if (ill) return DEP_PAT;
        case (m)
            2'd0: begin
                k   = t % (2*N - 2);
                pos = (k <= N - 1) ? k : (2*N - 2 - k);
                return N'(1 << pos);
            end
            2'd1: return N'(1 << (t % N));
            2'd2: return N'(1 << ((N - (t % N)) % N));
            default: begin
                k = t % (2*N);
                if (k < N) return N'((1 << (k + 1)) - 1);
                return N'((FULL << (k - N + 1)) & FULL);
            end
        endcase
    endfunction

    function automatic bit exp_dir(input logic [1:0] m, input int t, input bit ill);
        int k;
        if (ill) return 1'b0;
        case (m)
            2'd0: begin
                k = t % (2*N - 2);
                if (t == 0) return 1'b0;
                return (k >= N) || (k == 0);
            end
            2'd1: return 1'b0;
            2'd2: return (t > 0);
            default: return ((t % (2*N)) >= N);
        endcase
    endfunction

    // Model update on each edge, compare just after it
    always @(posedge clk) begin
        if (rst) begin
            mq_m    = mode;
            t_m     = 0;
            ill_m   = 1'b0;
            cnt_m   = 0;
            step_m  = 1'b0;
            valid_m = 1'b1;
        end else begin
            chg_m = (mode != mq_m);
            mq_m  = mode;
            if (chg_m) begin
                t_m    = 0;
                ill_m  = 1'b0;
                cnt_m  = 0;
                step_m = 1'b0;
            end else if (en) begin
                tk_m   = (cnt_m >= int'(div));
                step_m = tk_m;
                cnt_m  = tk_m ? 0 : cnt_m + 1;
                if (tk_m) begin
                    if (ill_m && mq_m != 2'd3) begin
                        ill_m = 1'b0;
                        t_m   = 0;
                    end else begin
                        t_m++;
                    end
                end
            end else begin
                step_m = 1'b0;
            end
        end
        #1;
        if (valid_m) begin
            chk("m_leds", 32'(leds), 32'(exp_leds(mq_m, t_m, ill_m)));
            chk("m_dir",  32'(dir),  32'(exp_dir(mq_m, t_m, ill_m)));
            chk("m_step", 32'(step), 32'(step_m));
            chk("m_cnt",  32'(dut.u_tick.cnt), 32'(cnt_m));
        end
    end

    logic [N-1:0] bounce_tbl [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                     4'b0100, 4'b0010, 4'b0001, 4'b0010};

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        mode = 2'd0;
        div  = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Bounce, one step per cycle
        chk("bnc_rst_leds", 32'(leds), 32'h1);
        chk("bnc_rst_dir",  32'(dir),  32'h0);
        chk("bnc_rst_step", 32'(step), 32'h0);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("bnc_seq", 32'(leds), 32'(bounce_tbl[i]));
            chk("bnc_step", 32'(step), 32'h1);
        end

        // Rotate-left every third cycle, then rotate-right
        mode = 2'd1;
        div  = 4'd2;
        repeat (4) @(negedge clk);
        chk("rotl_first", 32'(leds), 32'h2);
        chk("rotl_step",  32'(step), 32'h1);
        repeat (9) @(negedge clk);
        chk("rotl_wrap", 32'(leds), 32'h1);
        mode = 2'd2;
        repeat (4) @(negedge clk);
        chk("rotr_first", 32'(leds), 32'h8);
        chk("rotr_dir",   32'(dir),  32'h1);
        repeat (6) @(negedge clk);
        chk("rotr_third", 32'(leds), 32'h2);

        // Fill/drain at full rate
        mode = 2'd3;
        div  = 4'd0;
        repeat (8) @(negedge clk);
        chk("fill_empty", 32'(leds), 32'h0);
        chk("fill_dir1",  32'(dir),  32'h1);
        @(negedge clk);
        chk("fill_restart", 32'(leds), 32'h1);
        chk("fill_dir0",    32'(dir),  32'h0);

        // Mid-animation switch from bounce to fill
        mode = 2'd0;
        div  = 4'd5;
        repeat (14) @(negedge clk);
        chk("sw_pre_leds", 32'(leds), 32'h4);
        chk("sw_pre_cnt",  32'(dut.u_tick.cnt), 32'h1);
        mode = 2'd3;
        @(negedge clk);
        chk("sw_leds", 32'(leds), 32'h1);
        chk("sw_step", 32'(step), 32'h0);
        chk("sw_cnt",  32'(dut.u_tick.cnt), 32'h0);
        repeat (5) @(negedge clk);
        chk("sw_wait", 32'(leds), 32'h1);
        @(negedge clk);
        chk("sw_fill1", 32'(leds), 32'h3);
        chk("sw_fstep", 32'(step), 32'h1);

        // Freeze with en low, lower div below the held count
        mode = 2'd1;
        div  = 4'd9;
        repeat (8) @(negedge clk);
        chk("frz_cnt7", 32'(dut.u_tick.cnt), 32'h7);
        en  = 1'b0;
        div = 4'd1;
        repeat (10) @(negedge clk);
        chk("frz_leds", 32'(leds), 32'h1);
        chk("frz_cnt",  32'(dut.u_tick.cnt), 32'h7);
        chk("frz_step", 32'(step), 32'h0);
        en = 1'b1;
        @(negedge clk);
        chk("frz_resume", 32'(leds), 32'h2);
        chk("frz_rstep",  32'(step), 32'h1);

        // Reset coinciding with a tick and a mode change
        div  = 4'd0;
        mode = 2'd2;
        rst  = 1'b1;
        @(negedge clk);
        chk("rst_leds", 32'(leds), 32'h1);
        chk("rst_dir",  32'(dir),  32'h0);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_cnt",  32'(dut.u_tick.cnt), 32'h0);
        rst  = 1'b0;
        mode = 2'd1;
        repeat (3) @(negedge clk);
        chk("dep_pre", 32'(leds), 32'h4);

        // Corrupt the bar while frozen, expect recovery on the next tick
        en = 1'b0;
        force dut.leds = DEP_PAT;
        ill_m = 1'b1;
        @(negedge clk);
        release dut.leds;
        chk("dep_hold", 32'(leds), 32'(DEP_PAT));
        en = 1'b1;
        @(negedge clk);
        chk("dep_recover", 32'(leds), 32'h1);
        chk("dep_step",    32'(step), 32'h1);

        // Mode change while frozen still reloads
        repeat (2) @(negedge clk);
        en   = 1'b0;
        mode = 2'd2;
        repeat (2) @(negedge clk);
        chk("frz_reload", 32'(leds), 32'h1);
        chk("frz_rdir",   32'(dir),  32'h0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
